// File: rtl/mapper_hyper_ctl_if.sv
// Mapper and configuration bus for the hypervisor mapping sequencer.
interface mapper_hyper_ctl_if;
  logic       ready;
  logic       trap_req;
  logic       exit_req;
  logic [7:0] map_reg;
  logic [1:0] map_reg_sel;
  logic [7:0] map_reg_hyper;
  logic       load_map_hyper;
  logic       map_enable_ext;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_hyp_map_en;
  logic [7:0] shadow_rdata;
  logic       hyper_active;
  logic       busy;
  logic       done;

  // Sequencer side: drives the mapper and reports status.
  modport master (
    input  ready, trap_req, exit_req, map_reg,
    input  cfg_we, cfg_addr, cfg_wdata, cfg_hyp_map_en,
    output map_reg_sel, map_reg_hyper, load_map_hyper, map_enable_ext,
    output shadow_rdata, hyper_active, busy, done
  );

  // CPU / mapper side.
  modport slave (
    output ready, trap_req, exit_req, map_reg,
    output cfg_we, cfg_addr, cfg_wdata, cfg_hyp_map_en,
    input  map_reg_sel, map_reg_hyper, load_map_hyper, map_enable_ext,
    input  shadow_rdata, hyper_active, busy, done
  );
endinterface

// File: rtl/mapper_hyper_ctl.sv
// Hypervisor mapper switch: saves the four user mapper registers into a
// shadow array while loading the hypervisor map, and restores them on exit.
module mapper_hyper_ctl (
  input logic                clk,
  input logic                reset,
  mapper_hyper_ctl_if.master bus
);
  localparam int unsigned DW   = 8;
  localparam int unsigned IW   = 2;
  localparam int unsigned NREG = 4;

  typedef enum logic [1:0] {
    ST_USER  = 2'd0,
    ST_ENTER = 2'd1,
    ST_HYPER = 2'd2,
    ST_EXIT  = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   idx, idx_next;
  logic [DW-1:0]   shadow  [NREG];
  logic [DW-1:0]   hyp_map [NREG];
  logic            shadow_we;
  logic [IW-1:0]   sel;
  logic [DW-1:0]   hdata;
  logic            load;
  logic            done_int;

  // State and sequence index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_USER;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Shadow capture and hypervisor map configuration storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        shadow[i]  <= '0;
        hyp_map[i] <= '0;
      end
    end else begin
      if (shadow_we) shadow[idx] <= bus.map_reg;
      if (bus.cfg_we) hyp_map[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  // Next-state and mapper strobe generation; reset suppresses all strobes.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    sel        = bus.cfg_addr;
    load       = 1'b0;
    hdata      = '0;
    done_int   = 1'b0;
    shadow_we  = 1'b0;
    case (state)
      ST_USER: begin
        if (bus.trap_req && bus.ready) begin
          state_next = ST_ENTER;
          idx_next   = '0;
        end
      end
      ST_ENTER: begin
        sel = idx;
        if (bus.ready) begin
          shadow_we = 1'b1;
          load      = 1'b1;
          hdata     = hyp_map[idx];
          if (idx == IW'(NREG - 1)) begin
            state_next = ST_HYPER;
            idx_next   = '0;
            done_int   = 1'b1;
          end else begin
            idx_next = IW'(idx + IW'(1));
          end
        end
      end
      ST_HYPER: begin
        if (bus.exit_req && bus.ready) begin
          state_next = ST_EXIT;
          idx_next   = '0;
        end
      end
      ST_EXIT: begin
        sel = idx;
        if (bus.ready) begin
          load  = 1'b1;
          hdata = shadow[idx];
          if (idx == IW'(NREG - 1)) begin
            state_next = ST_USER;
            idx_next   = '0;
            done_int   = 1'b1;
          end else begin
            idx_next = IW'(idx + IW'(1));
          end
        end
      end
      default: begin
        state_next = ST_USER;
        idx_next   = '0;
      end
    endcase
    if (reset) begin
      load      = 1'b0;
      hdata     = '0;
      done_int  = 1'b0;
      shadow_we = 1'b0;
    end
  end

  // Mapper-facing and status outputs follow state directly.
  assign bus.map_reg_sel    = sel;
  assign bus.map_reg_hyper  = hdata;
  assign bus.load_map_hyper = load;
  assign bus.done           = done_int;
  assign bus.map_enable_ext = (reset || state == ST_USER) ? 1'b1 : bus.cfg_hyp_map_en;
  assign bus.hyper_active   = !reset && (state != ST_USER);
  assign bus.busy           = !reset && (state == ST_ENTER || state == ST_EXIT);
  assign bus.shadow_rdata   = shadow[bus.cfg_addr];
endmodule

// File: doc/mapper_hyper_ctl.md
MAPPER_HYPER_CTL -- requirements
Module: mapper_hyper_ctl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ready  in  1  CPU bus ready; the sequencer advances only when ready=1.
REQ-004 trap_req  in  1  request to enter hypervisor mode; level, sampled in USER state.
REQ-005 exit_req  in  1  request to leave hypervisor mode; level, sampled in HYPER state.
REQ-006 map_reg  in  8  current mapper register byte selected by map_reg_sel (combinational from mapper).
REQ-007 map_reg_sel  out  2  mapper register index (0=A offset lo, 1=X, 2=Y offset lo, 3=Z).
REQ-008 map_reg_hyper  out  8  byte to load into the selected mapper register.
REQ-009 load_map_hyper  out  1  load strobe to mapper; write occurs at the clock edge where it is 1.
REQ-010 map_enable_ext  out  1  mapper global enable.
REQ-011 cfg_we  in  1  hypervisor-map config write strobe.
REQ-012 cfg_addr  in  2  config/shadow byte index.
REQ-013 cfg_wdata  in  8  config write data; cfg_addr=0..3 writes hyp_map[0..3].
REQ-014 cfg_hyp_map_en  in  1  value of map_enable_ext while not in USER state.
REQ-015 shadow_rdata  out  8  shadow[cfg_addr], combinational.
REQ-016 hyper_active  out  1  1 in ENTER, HYPER and EXIT states.
REQ-017 busy  out  1  1 in ENTER and EXIT states.
REQ-018 done  out  1  one-cycle pulse on completion of an ENTER or EXIT sequence.

Function
REQ-019 States: USER, ENTER, HYPER, EXIT. Internal 2-bit index idx, 4x8 shadow array, 4x8 hyp_map array.
REQ-020 USER: trap_req=1 & ready=1 -> ENTER, idx<=0; exit_req is ignored.
REQ-021 ENTER cycle with ready=1: map_reg_sel=idx, shadow[idx]<=map_reg, map_reg_hyper=hyp_map[idx], load_map_hyper=1, idx<=idx+1.
REQ-022 Save and load of the same index happen in the same cycle: the capture takes the pre-edge value and the mapper loads at that edge.
REQ-023 ENTER: on the cycle with idx=3 and ready=1, go to HYPER, idx<=0, done=1.
REQ-024 ENTER and EXIT cycles with ready=0: load_map_hyper=0; idx, state, shadow and mapper registers hold; map_reg_sel=idx.
REQ-025 HYPER: exit_req=1 & ready=1 -> EXIT, idx<=0; trap_req is ignored (no nesting).
REQ-026 EXIT cycle with ready=1: map_reg_sel=idx, map_reg_hyper=shadow[idx], load_map_hyper=1, idx<=idx+1.
REQ-027 EXIT: on idx=3 with ready=1, go to USER, done=1.
REQ-028 Entry and exit each take exactly 4 ready cycles after the accepting cycle; the sequence is never reordered or skipped.
REQ-029 load_map_hyper is 0 in USER and HYPER states.
REQ-030 map_reg_sel=cfg_addr in USER and HYPER states, giving the hypervisor mapper readback.
REQ-031 map_reg_hyper=0 whenever load_map_hyper=0.
REQ-032 map_enable_ext=1 in USER state and cfg_hyp_map_en in all other states, combinational from state.
REQ-033 cfg_we writes hyp_map[cfg_addr] at the edge in any state.
REQ-034 A cfg_we during ENTER to an index not yet loaded affects that load; a write to an already-loaded index does not.
REQ-035 idx is 2 bits and wraps 3->0 only on a state exit; there is no other wrap path.
REQ-036 Simultaneous trap_req and exit_req: trap_req is honoured in USER and exit_req in HYPER; no other combination is acted on.

Reset
REQ-037 Reset has priority over all other inputs in every state, including mid-ENTER and mid-EXIT.
REQ-038 Reset values: state=USER, idx=0, shadow[*]=0, hyp_map[*]=0.
REQ-039 Outputs during reset: load_map_hyper=0, done=0, busy=0, hyper_active=0, map_enable_ext=1.
REQ-040 Reset mid-sequence does not complete the sequence; the mapper keeps the registers already written and is reset by its own reset.

Verification
REQ-041 Entry: hyp_map={11,22,33,44}, mapper regs={A1,B2,C3,D4}, trap_req with ready=1 -> 4 loads of 11,22,33,44 at sel 0..3; shadow={A1,B2,C3,D4}; done on the 4th cycle; hyper_active=1.
REQ-042 Exit: from the REQ-041 end state, exit_req -> 4 loads of A1,B2,C3,D4 at sel 0..3; done pulses; state USER; map_enable_ext=1.
REQ-043 Stall: ready=0 for 3 cycles after the second ENTER load -> no strobes during the stall; idx stays 2; remaining loads of 33,44 follow; total 4 strobes.
REQ-044 Conflicts: trap_req=exit_req=1 in USER -> ENTER. trap_req in HYPER -> no change. exit_req in USER -> no change.
REQ-045 Reset after 2 ENTER loads -> next cycle state USER, busy=0, shadow all 0, load_map_hyper=0.
REQ-046 cfg_hyp_map_en=0: map_enable_ext=0 from the first ENTER cycle through EXIT, and 1 after return to USER.
